qed_inst_constraints_seq: RTL and testbench



---
 rtl/qed_constraints_pkg.sv | 30 +++
 rtl/qed_inst_classify.sv | 76 +++++++
 rtl/qed_inst_constraints_seq.sv | 130 +++++++++++++
 tb/tb_qed_inst_constraints_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qed_constraints_pkg.sv
// Shared encodings for the QED instruction-constraint checker.
// Class codes, phase codes and the RV32 opcodes the classifier recognises.
package qed_constraints_pkg;

  localparam int unsigned CLS_W   = 3;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned INST_W  = 32;

  typedef enum logic [CLS_W-1:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LW   = 3'd3,
    CLS_SW   = 3'd4,
    CLS_NOP  = 3'd5
  } inst_cls_e;

  typedef enum logic [PHASE_W-1:0] {
    PH_ORIG  = 2'd0,
    PH_DRAIN = 2'd1,
    PH_HOLD  = 2'd2
  } phase_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_NOP    = 7'b1111111;

endpackage

// File: rtl/qed_inst_classify.sv
// Combinational RV32IM instruction classifier with register-split rule.
// Ports:
//   instruction - 32-bit instruction word
//   inst_class  - class code (CLS_NONE when not in the legal subset)
module qed_inst_classify
  import qed_constraints_pkg::*;
#(
  parameter int unsigned REG_SPLIT    = 16,
  parameter int unsigned MUL_EN       = 1,
  parameter int unsigned MEM_BASE_REG = 0
) (
  input  logic [INST_W-1:0] instruction,
  output logic [CLS_W-1:0]  inst_class
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  logic rd_ok, rs1_ok, rs2_ok;
  logic r_func_ok, i_func_ok, mem_ok;

  // One extra bit so REG_SPLIT=16..32 compares without truncation.
  assign rd_ok  = {1'b0, rd}  < 6'(REG_SPLIT);
  assign rs1_ok = {1'b0, rs1} < 6'(REG_SPLIT);
  assign rs2_ok = {1'b0, rs2} < 6'(REG_SPLIT);

  // Legal memory ops use the fixed base register and a small positive offset.
  assign mem_ok = (funct3 == 3'b010) && (rs1 == 5'(MEM_BASE_REG))
                  && (instruction[31:30] == 2'b00);

  // R-type funct7/funct3 legality (M extension limited to MUL..MULHU).
  always_comb begin
    r_func_ok = 1'b0;
    case (funct7)
      7'b0000000: r_func_ok = 1'b1;
      7'b0100000: r_func_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
      7'b0000001: r_func_ok = (MUL_EN != 0) && !funct3[2];
      default:    r_func_ok = 1'b0;
    endcase
  end

  // Shift-immediates constrain the upper immediate bits; others take any imm.
  always_comb begin
    i_func_ok = 1'b1;
    case (funct3)
      3'b001:  i_func_ok = (funct7 == 7'b0000000);
      3'b101:  i_func_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      default: i_func_ok = 1'b1;
    endcase
  end

  // Class selection.
  always_comb begin
    inst_class = CLS_NONE;
    case (opcode)
      OPC_OP:     if (r_func_ok && rd_ok && rs1_ok && rs2_ok) inst_class = CLS_R;
      OPC_OP_IMM: if (i_func_ok && rd_ok && rs1_ok)           inst_class = CLS_I;
      OPC_LOAD:   if (mem_ok && rd_ok)                        inst_class = CLS_LW;
      OPC_STORE:  if (mem_ok && rs2_ok)                       inst_class = CLS_SW;
      OPC_NOP:    inst_class = CLS_NOP;
      default:    inst_class = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/qed_inst_constraints_seq.sv
// Stateful instruction-legality checker for the QED harness: bounded original
// sequence, NOP-only drain, then NOP-only hold.
// Optional macro QED_CONSTRAINT_ASSUME_EN adds formal assume/assert statements.
// Ports:
//   clk, reset_x   - clock, async active-low reset
//   inst_valid     - instruction presented this cycle
//   instruction    - RV32IM instruction word
//   inst_ok        - combinational legality in current phase
//   inst_class     - combinational class code
//   phase          - registered phase
//   orig_cnt       - accepted non-NOP count (saturates at MAX_ORIG)
//   viol           - sticky illegal-instruction flag
//   seq_done       - high in PH_HOLD
module qed_inst_constraints_seq
  import qed_constraints_pkg::*;
#(
  parameter  int unsigned REG_SPLIT    = 16,
  parameter  int unsigned MAX_ORIG     = 8,
  parameter  int unsigned DRAIN_CYCLES = 4,
  parameter  int unsigned MUL_EN       = 1,
  parameter  int unsigned MEM_BASE_REG = 0,
  localparam int unsigned OCW          = $clog2(MAX_ORIG + 1)
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                inst_valid,
  input  logic [INST_W-1:0]   instruction,
  output logic                inst_ok,
  output logic [CLS_W-1:0]    inst_class,
  output logic [PHASE_W-1:0]  phase,
  output logic [OCW-1:0]      orig_cnt,
  output logic                viol,
  output logic                seq_done
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  phase_e         phase_q, phase_d;
  logic [OCW-1:0] orig_cnt_q, orig_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           viol_q, viol_d;
  logic           seq_done_q, seq_done_d;
  logic           is_nop;

  qed_inst_classify #(
    .REG_SPLIT    (REG_SPLIT),
    .MUL_EN       (MUL_EN),
    .MEM_BASE_REG (MEM_BASE_REG)
  ) u_classify (
    .instruction (instruction),
    .inst_class  (inst_class)
  );

  // After the original phase only NOPs are legal.
  assign is_nop  = (inst_class == CLS_NOP);
  assign inst_ok = (inst_class != CLS_NONE) && ((phase_q == PH_ORIG) || is_nop);

  // State register.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      phase_q     <= PH_ORIG;
      orig_cnt_q  <= '0;
      drain_cnt_q <= '0;
      viol_q      <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      orig_cnt_q  <= orig_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      viol_q      <= viol_d;
      seq_done_q  <= seq_done_d;
    end
  end

  // Next-state: illegal instructions only set viol; nothing else advances.
  always_comb begin
    phase_d     = phase_q;
    orig_cnt_d  = orig_cnt_q;
    drain_cnt_d = drain_cnt_q;
    viol_d      = viol_q;
    seq_done_d  = seq_done_q;
    if (inst_valid) begin
      if (!inst_ok) begin
        viol_d = 1'b1;
      end else begin
        case (phase_q)
          PH_ORIG: begin
            if (!is_nop && (orig_cnt_q != OCW'(MAX_ORIG))) begin
              orig_cnt_d = orig_cnt_q + OCW'(1);
              if (orig_cnt_d == OCW'(MAX_ORIG)) begin
                phase_d     = PH_DRAIN;
                drain_cnt_d = '0;
              end
            end
          end
          PH_DRAIN: begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
            if (drain_cnt_d == DCW'(DRAIN_CYCLES)) begin
              phase_d    = PH_HOLD;
              seq_done_d = 1'b1;
            end
          end
          default: begin
            phase_d = phase_q;
          end
        endcase
      end
    end
  end

  assign phase    = phase_q;
  assign orig_cnt = orig_cnt_q;
  assign viol     = viol_q;
  assign seq_done = seq_done_q;

`ifdef QED_CONSTRAINT_ASSUME_EN
  // Constrain the formal instruction source and prove viol never rises.
  always @(posedge clk) begin
    if (reset_x) begin
      if (inst_valid) begin
        assume (inst_ok);
      end
      assert (!viol_q);
    end
  end
`else
  // No formal statements: viol is the only indication of an illegal input.
`endif

endmodule

// File: tb/tb_qed_inst_constraints_seq.sv
// Directed bench for qed_inst_constraints_seq (MUL_EN=1 main DUT, MUL_EN=0 side DUT).
module tb_qed_inst_constraints_seq;

  logic        clk;
  logic        reset_x;
  logic        inst_valid;
  logic [31:0] instruction;

  logic        inst_ok,  inst_ok0;
  logic [2:0]  inst_class, inst_class0;
  logic [1:0]  phase, phase0;
  logic [3:0]  orig_cnt, orig_cnt0;
  logic        viol, viol0;
  logic        seq_done, seq_done0;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADD    = 32'h003100B3;
  localparam logic [31:0] I_ADD17  = 32'h003108B3;
  localparam logic [31:0] I_MUL    = 32'h023100B3;
  localparam logic [31:0] I_NOP    = 32'h0000007F;
  localparam logic [31:0] I_ADDI   = 32'h00510093;
  localparam logic [31:0] I_LW     = 32'h00002083;
  localparam logic [31:0] I_LW_BAD = 32'h00012083;
  localparam logic [31:0] I_SW     = 32'h00302023;
  localparam logic [31:0] I_SUB    = 32'h403100B3;
  localparam logic [31:0] I_SRAI   = 32'h40315093;
  localparam logic [31:0] I_SLLI_B = 32'h40311093;

  qed_inst_constraints_seq #(
    .REG_SPLIT(16), .MAX_ORIG(8), .DRAIN_CYCLES(4), .MUL_EN(1), .MEM_BASE_REG(0)
  ) u_dut (
    .clk(clk), .reset_x(reset_x), .inst_valid(inst_valid), .instruction(instruction),
    .inst_ok(inst_ok), .inst_class(inst_class), .phase(phase), .orig_cnt(orig_cnt),
    .viol(viol), .seq_done(seq_done)
  );

  qed_inst_constraints_seq #(
    .REG_SPLIT(16), .MAX_ORIG(8), .DRAIN_CYCLES(4), .MUL_EN(0), .MEM_BASE_REG(0)
  ) u_dut_nomul (
    .clk(clk), .reset_x(reset_x), .inst_valid(inst_valid), .instruction(instruction),
    .inst_ok(inst_ok0), .inst_class(inst_class0), .phase(phase0), .orig_cnt(orig_cnt0),
    .viol(viol0), .seq_done(seq_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge so they settle before the next rise.
  task automatic set(input logic v, input logic [31:0] ins);
    @(negedge clk);
    inst_valid  = v;
    instruction = ins;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_x     = 1'b0;
    inst_valid  = 1'b0;
    instruction = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase",    32'(phase),      32'd0);
    chk("rst_orig_cnt", 32'(orig_cnt),   32'd0);
    chk("rst_viol",     32'(viol),       32'd0);
    chk("rst_seq_done", 32'(seq_done),   32'd0);
    chk("rst_cls_zero", 32'(inst_class), 32'd0);
    chk("rst_ok_zero",  32'(inst_ok),    32'd0);
    @(negedge clk);
    reset_x = 1'b1;

    // Run 1: mixed legal classes, one violation, reach drain.
    set(1'b1, I_ADD);
    chk("add_ok",  32'(inst_ok),    32'd1);
    chk("add_cls", 32'(inst_class), 32'd1);
    tick();
    chk("add_cnt", 32'(orig_cnt), 32'd1);

    set(1'b1, I_ADD17);
    chk("add17_ok",  32'(inst_ok),    32'd0);
    chk("add17_cls", 32'(inst_class), 32'd0);
    tick();
    chk("add17_viol", 32'(viol),     32'd1);
    chk("add17_cnt",  32'(orig_cnt), 32'd1);

    set(1'b1, I_MUL);
    chk("mul_ok_en1",  32'(inst_ok),     32'd1);
    chk("mul_cls_en1", 32'(inst_class),  32'd1);
    chk("mul_ok_en0",  32'(inst_ok0),    32'd0);
    chk("mul_cls_en0", 32'(inst_class0), 32'd0);
    tick();
    chk("mul_cnt",    32'(orig_cnt), 32'd2);
    chk("viol_stick", 32'(viol),     32'd1);

    set(1'b1, I_NOP);
    chk("nop_cls", 32'(inst_class), 32'd5);
    chk("nop_ok",  32'(inst_ok),    32'd1);
    tick();
    chk("nop_nocount", 32'(orig_cnt), 32'd2);

    set(1'b1, I_ADDI);
    chk("addi_cls", 32'(inst_class), 32'd2);
    tick();
    chk("addi_cnt", 32'(orig_cnt), 32'd3);

    set(1'b1, I_LW);
    chk("lw_cls", 32'(inst_class), 32'd3);
    tick();
    chk("lw_cnt", 32'(orig_cnt), 32'd4);

    set(1'b0, I_LW_BAD);
    chk("lw_bad_cls", 32'(inst_class), 32'd0);
    chk("lw_bad_ok",  32'(inst_ok),    32'd0);
    tick();
    chk("invalid_hold_cnt", 32'(orig_cnt), 32'd4);

    set(1'b1, I_SW);
    chk("sw_cls", 32'(inst_class), 32'd4);
    tick();
    chk("sw_cnt", 32'(orig_cnt), 32'd5);

    set(1'b1, I_SUB);
    chk("sub_cls", 32'(inst_class), 32'd1);
    tick();

    set(1'b0, I_SLLI_B);
    chk("slli_bad_cls", 32'(inst_class), 32'd0);

    set(1'b1, I_SRAI);
    chk("srai_cls", 32'(inst_class), 32'd2);
    tick();
    chk("srai_cnt",   32'(orig_cnt), 32'd7);
    chk("pre8_phase", 32'(phase),    32'd0);

    set(1'b1, I_NOP);
    tick();
    set(1'b1, I_ADD);
    tick();
    chk("eighth_cnt",   32'(orig_cnt), 32'd8);
    chk("eighth_phase", 32'(phase),    32'd1);

    set(1'b0, I_ADDI);
    chk("drain_addi_ok",  32'(inst_ok),    32'd0);
    chk("drain_addi_cls", 32'(inst_class), 32'd2);
    set(1'b1, I_NOP);
    chk("drain_nop_ok", 32'(inst_ok), 32'd1);
    tick();
    set(1'b1, I_NOP);
    tick();
    chk("drain2_phase", 32'(phase), 32'd1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset_x = 1'b0;
    #1;
    chk("async_phase", 32'(phase),    32'd0);
    chk("async_cnt",   32'(orig_cnt), 32'd0);
    chk("async_viol",  32'(viol),     32'd0);
    tick();
    @(negedge clk);
    reset_x    = 1'b1;
    inst_valid = 1'b0;

    // Run 2: eight ADDs straight into drain, then four NOPs with gaps.
    set(1'b1, I_ADD);
    tick();
    chk("fresh_cnt", 32'(orig_cnt), 32'd1);
    for (int i = 1; i < 8; i++) begin
      set(1'b1, I_ADD);
      tick();
    end
    chk("r2_phase_drain", 32'(phase),    32'd1);
    chk("r2_cnt",         32'(orig_cnt), 32'd8);
    for (int i = 0; i < 3; i++) begin
      set(1'b1, I_NOP);
      tick();
      set(1'b0, I_NOP);
      tick();
    end
    chk("r2_pre4_phase", 32'(phase),    32'd1);
    chk("r2_pre4_done",  32'(seq_done), 32'd0);
    set(1'b1, I_NOP);
    tick();
    chk("hold_phase", 32'(phase),    32'd2);
    chk("hold_done",  32'(seq_done), 32'd1);
    chk("r2_viol",    32'(viol),     32'd0);

    set(1'b1, I_NOP);
    tick();
    chk("hold_stays", 32'(phase),    32'd2);
    chk("hold_sat",   32'(orig_cnt), 32'd8);
    set(1'b0, I_ADD);
    chk("hold_add_ok", 32'(inst_ok), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
